round_controller: RTL and testbench
===================================

Name: round_controller

Overview:
- Sequences the hit-or-miss game. Starts the game and schedules every round.
- Pulses the LED sequencer for a new pattern and runs the per-round millisecond countdown.
- Raises the expiry strobe consumed by the hit FSM, tracks misses and level, shortens rounds as level rises, and ends the game after too many misses.
- Sits in top_level between the start button, the LED sequencer and the hit/score FSM.

Parameters:
- TICK_DIV, 50000: clk cycles per 1 ms tick (50 MHz).
- ROUND_MS_INIT, 1000: round length at level 0, in ms (max 4095).
- ROUND_MS_MIN, 250: floor on round length, in ms.
- ROUND_MS_STEP, 50: round length reduction per level-up, in ms.
- HITS_PER_LEVEL, 5: hits required per level-up.
- MAX_MISSES, 3: misses that end the game (1..15).
- GAP_MS, 200: inter-round pause, in ms.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start_in  in  1  start button level, already synchronised; acts on rising edge
- hit_in  in  1  one-cycle hit pulse from the hit FSM
- new_round_out  out  1  one-cycle pulse; sequencer loads a new pattern
- round_active_out  out  1  high while the hit window is open
- timer_expired_out  out  1  one-cycle pulse on round timeout
- ms_left_out  out  12  remaining ms in the current round
- level_out  out  4  current level, saturates at 15
- misses_out  out  4  misses so far
- game_over_out  out  1  high in GAME_OVER

Behaviour:
- Reset: all outputs 0, state IDLE, round_ms=ROUND_MS_INIT, hit count 0, prescaler 0, start_prev=1. A button held through reset does not start a game.
- Outputs are registered or decoded from state registers only. No combinational input-to-output path.
- start_edge = start_in & ~start_prev.
- Prescaler: counts 0..TICK_DIV-1 in WAIT and GAP only. tick is asserted at TICK_DIV-1. Cleared in ARM and on entry to GAP.
- IDLE: on start_edge, clear misses, level and hit count, set round_ms=INIT, go to ARM.
- ARM (1 cycle): new_round_out=1, ms_left=round_ms, then WAIT.
- WAIT: round_active_out=1. Each tick decrements ms_left.
  - On hit_in: hit count++. If hit count reaches HITS_PER_LEVEL: hit count=0, level++ (saturating), round_ms=max(round_ms-STEP, MIN). Then ms_left=0, go to GAP.
  - On the tick where ms_left==1: ms_left=0 and timer_expired_out pulses. Its 1 is registered in the same cycle that misses_out updates and the state changes.
  - Timeout destination: if misses+1==MAX_MISSES go to GAME_OVER, else GAP.
  - Expiry therefore occurs round_ms*TICK_DIV cycles after the first WAIT cycle.
- GAP: countdown of GAP_MS ticks, then ARM. hit_in ignored.
- GAME_OVER: game_over_out=1, outputs frozen except pulses (held 0). start_edge reinitialises as in IDLE and goes to ARM.
- hit_in and an expiry tick in the same cycle: the hit wins; no miss, no expiry pulse.
- hit_in outside WAIT: ignored.
- start_edge outside IDLE and GAME_OVER: ignored.
- Subtraction is computed at 13 bits before clamping, so round_ms never underflows.
- level saturates at 15. round_ms keeps clamping at MIN.
- reset_n low at any time: immediate asynchronous return to reset values.
- Illegal state encoding: recover to IDLE.

Optional Feature:
- Macro: ROUND_CTRL_PAUSE_EN.
- With it defined:
  - Adds input pause_in (1 bit).
  - While pause_in=1 in WAIT or GAP, the prescaler and ms_left are frozen, round_active_out=0 and hit_in is ignored.
  - On release, counting resumes from the frozen values.
- Without it: no port; behaviour as above.

Decomposition:
- game_pkg:
  - round_state_t enum {IDLE, ARM, WAIT, GAP, GAME_OVER} on 3 bits.
  - Constants MS_W=12, LEVEL_W=4, MISS_W=4.
- Sub-module ms_tick_gen (params TICK_DIV; ports clk, reset_n, clear, enable, tick). Instantiated once.

Test Plan (all tests use TICK_DIV=4, ROUND_MS_INIT=10, ROUND_MS_MIN=6, ROUND_MS_STEP=2, HITS_PER_LEVEL=2, MAX_MISSES=3, GAP_MS=2):
- Reset with start_in held at 1 -> all outputs 0, no game starts. start_in 0 then 1 -> new_round_out high exactly 1 cycle, then round_active_out=1 and ms_left_out=10.
- No hits -> timer_expired_out pulses 40 cycles after round_active_out rises, misses_out=1, next new_round_out 8 cycles later. Third timeout -> game_over_out=1, misses_out=3, no further new_round_out.
- Two hits -> level_out=1, next round ms_left_out=8. Four more hits -> level_out=3, round length 6 (clamped), stays 6 afterwards.
- hit_in asserted on the same cycle as the final tick -> misses_out unchanged, no timer_expired_out, hit count incremented.
- reset_n pulsed low mid-WAIT -> outputs 0 the same cycle, state IDLE. A stray hit_in in GAP/IDLE -> ignored.
- With ROUND_CTRL_PAUSE_EN defined: pause_in high for 20 cycles mid-WAIT -> ms_left_out frozen, expiry delayed by exactly 20 cycles.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and widths for the hit-or-miss game blocks.
package game_pkg;

    localparam int MS_W    = 12;
    localparam int LEVEL_W = 4;
    localparam int MISS_W  = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        WAIT      = 3'd2,
        GAP       = 3'd3,
        GAME_OVER = 3'd4
    } round_state_t;

    // One extra bit on the difference so a step larger than the current length clamps instead of wrapping.
    function automatic logic [MS_W-1:0] shorten_round(input logic [MS_W-1:0] cur,
                                                      input logic [MS_W-1:0] step,
                                                      input logic [MS_W-1:0] floor_ms);
        logic [MS_W:0] diff;
        diff = {1'b0, cur} - {1'b0, step};
        if (diff[MS_W] || (diff[MS_W-1:0] < floor_ms))
            return floor_ms;
        return diff[MS_W-1:0];
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick on the last count of each TICK_DIV window.
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/round_controller.sv
// Game sequencer: arms rounds, runs the ms countdown, tracks hits/misses/level.
// Optional ROUND_CTRL_PAUSE_EN adds pause_in, which freezes WAIT/GAP timing.
module round_controller
    import game_pkg::*;
#(
    parameter int TICK_DIV       = 50000,
    parameter int ROUND_MS_INIT  = 1000,
    parameter int ROUND_MS_MIN   = 250,
    parameter int ROUND_MS_STEP  = 50,
    parameter int HITS_PER_LEVEL = 5,
    parameter int MAX_MISSES     = 3,
    parameter int GAP_MS         = 200
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_in,
    input  logic              hit_in,
`ifdef ROUND_CTRL_PAUSE_EN
    input  logic              pause_in,
`endif
    output logic              new_round_out,
    output logic              round_active_out,
    output logic              timer_expired_out,
    output logic [MS_W-1:0]   ms_left_out,
    output logic [LEVEL_W-1:0] level_out,
    output logic [MISS_W-1:0] misses_out,
    output logic              game_over_out
);

    localparam int HIT_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL + 1) : 1;

    round_state_t      state, state_n;
    logic              start_prev, start_edge;
    logic              tick, tick_en, tick_clear, paused;
    logic              start_game, hit_ev, expire_ev;
    logic [MS_W-1:0]   ms_left, round_ms, gap_cnt;
    logic [LEVEL_W-1:0] level;
    logic [MISS_W-1:0] misses;
    logic [HIT_W-1:0]  hit_cnt, hit_cnt_inc;
    logic              timer_expired;

    assign start_edge  = start_in & ~start_prev;
    assign hit_cnt_inc = hit_cnt + 1'b1;

`ifdef ROUND_CTRL_PAUSE_EN
    // Registered so round_active_out has no path from the pause pin.
    logic pause_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pause_q <= 1'b0;
        else          pause_q <= pause_in;
    end
    assign paused = pause_q && ((state == WAIT) || (state == GAP));
`else
    assign paused = 1'b0;
`endif

    assign tick_en = ((state == WAIT) || (state == GAP)) && !paused;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (tick_clear),
        .enable  (tick_en),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n    = state;
        tick_clear = 1'b0;
        start_game = 1'b0;
        hit_ev     = 1'b0;
        expire_ev  = 1'b0;
        case (state)
            IDLE, GAME_OVER: begin
                if (start_edge) begin
                    start_game = 1'b1;
                    state_n    = ARM;
                end
            end
            ARM: begin
                tick_clear = 1'b1;
                state_n    = WAIT;
            end
            WAIT: begin
                // A hit on the final tick takes priority over expiry.
                if (!paused && hit_in) begin
                    hit_ev     = 1'b1;
                    tick_clear = 1'b1;
                    state_n    = GAP;
                end else if (tick && (ms_left <= MS_W'(1))) begin
                    expire_ev  = 1'b1;
                    tick_clear = 1'b1;
                    state_n    = ((misses + 1'b1) == MISS_W'(MAX_MISSES)) ? GAME_OVER : GAP;
                end
            end
            GAP: begin
                if (tick && (gap_cnt <= MS_W'(1)))
                    state_n = ARM;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_prev    <= 1'b1;
            ms_left       <= '0;
            round_ms      <= MS_W'(ROUND_MS_INIT);
            gap_cnt       <= '0;
            level         <= '0;
            misses        <= '0;
            hit_cnt       <= '0;
            timer_expired <= 1'b0;
        end else begin
            start_prev    <= start_in;
            timer_expired <= expire_ev;

            if (start_game) begin
                misses   <= '0;
                level    <= '0;
                hit_cnt  <= '0;
                round_ms <= MS_W'(ROUND_MS_INIT);
            end

            if (state == ARM)
                ms_left <= round_ms;
            else if (hit_ev || expire_ev)
                ms_left <= '0;
            else if ((state == WAIT) && tick)
                ms_left <= ms_left - 1'b1;

            if (hit_ev || expire_ev)
                gap_cnt <= MS_W'(GAP_MS);
            else if ((state == GAP) && tick)
                gap_cnt <= gap_cnt - 1'b1;

            if (expire_ev)
                misses <= misses + 1'b1;

            if (hit_ev) begin
                if (hit_cnt_inc == HIT_W'(HITS_PER_LEVEL)) begin
                    hit_cnt  <= '0;
                    if (level != '1)
                        level <= level + 1'b1;
                    round_ms <= shorten_round(round_ms, MS_W'(ROUND_MS_STEP), MS_W'(ROUND_MS_MIN));
                end else begin
                    hit_cnt <= hit_cnt_inc;
                end
            end
        end
    end

    assign new_round_out     = (state == ARM);
    assign round_active_out  = (state == WAIT) && !paused;
    assign game_over_out     = (state == GAME_OVER);
    assign timer_expired_out = timer_expired;
    assign ms_left_out       = ms_left;
    assign level_out         = level;
    assign misses_out        = misses;

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: scripted round table, corner sequences, random games vs a round-level model.
module tb_round_controller;

    localparam int TD = 4, INIT = 10, MINL = 6, STEP = 2, HPL = 2, MAXM = 3, GAPM = 2;

    logic        clk = 1'b0;
    logic        reset_n, start_in, hit_in;
`ifdef ROUND_CTRL_PAUSE_EN
    logic        pause_in = 1'b0;
`endif
    logic        new_round_out, round_active_out, timer_expired_out, game_over_out;
    logic [11:0] ms_left_out;
    logic [3:0]  level_out, misses_out;

    int checks = 0;
    int failures = 0;
    int exp_pulses = 0;
    int nr_pulses = 0;

    round_controller #(
        .TICK_DIV(TD), .ROUND_MS_INIT(INIT), .ROUND_MS_MIN(MINL), .ROUND_MS_STEP(STEP),
        .HITS_PER_LEVEL(HPL), .MAX_MISSES(MAXM), .GAP_MS(GAPM)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start_in          (start_in),
        .hit_in            (hit_in),
`ifdef ROUND_CTRL_PAUSE_EN
        .pause_in          (pause_in),
`endif
        .new_round_out     (new_round_out),
        .round_active_out  (round_active_out),
        .timer_expired_out (timer_expired_out),
        .ms_left_out       (ms_left_out),
        .level_out         (level_out),
        .misses_out        (misses_out),
        .game_over_out     (game_over_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (timer_expired_out) exp_pulses <= exp_pulses + 1;
        if (new_round_out)     nr_pulses  <= nr_pulses + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start_in = 1'b0;
        step();
        start_in = 1'b1;
        step();
    endtask

    // Plays one round: hit at hit_off cycles after the window opens (<0 = let it expire).
    task automatic run_round(input int hit_off, input int exp_len, input int exp_level,
                             input int exp_misses, input bit exp_over, input bit gap_noise);
        int n, p0, nr0;
        n = 0;
        while (!new_round_out && n < 200) begin step(); n++; end
        chk("new_round_seen", int'(new_round_out), 1);
        step();
        chk("new_round_width", int'(new_round_out), 0);
        chk("round_active", int'(round_active_out), 1);
        chk("round_len", int'(ms_left_out), exp_len);
        p0 = exp_pulses;
        if (hit_off >= 0) begin
            repeat (hit_off) step();
            hit_in = 1'b1;
            step();
            hit_in = 1'b0;
            chk("active_after_hit", int'(round_active_out), 0);
            chk("ms_left_after_hit", int'(ms_left_out), 0);
        end else begin
            n = 0;
            while (!timer_expired_out && n < 5000) begin step(); n++; end
            chk("expiry_latency", n, exp_len * TD);
            chk("ms_left_at_expiry", int'(ms_left_out), 0);
        end
        step();
        chk("level", int'(level_out), exp_level);
        chk("misses", int'(misses_out), exp_misses);
        chk("expiry_pulses", exp_pulses - p0, (hit_off >= 0) ? 0 : 1);
        chk("game_over", int'(game_over_out), int'(exp_over));
        if (!exp_over) begin
            n = 1;
            while (!new_round_out && n < 200) begin
                if (gap_noise) begin
                    hit_in   = 1'b1;
                    start_in = n[0];
                end
                step();
                n++;
            end
            hit_in   = 1'b0;
            start_in = 1'b1;
            chk("gap_length", n, 8);
        end else begin
            nr0 = nr_pulses;
            repeat (60) step();
            chk("no_round_after_over", nr_pulses - nr0, 0);
            chk("over_held", int'(game_over_out), 1);
            chk("over_misses_frozen", int'(misses_out), exp_misses);
        end
    endtask

    typedef struct {
        int hit_off;
        int len;
        int level;
        int misses;
        bit over;
    } round_vec_t;

    round_vec_t tbl[11];

    int m_round_ms, m_level, m_hits, m_misses, off, rounds;
    bit m_over, do_hit;

    initial begin
        tbl[0]  = '{5,  10, 0, 0, 1'b0};
        tbl[1]  = '{3,  10, 1, 0, 1'b0};
        tbl[2]  = '{-1, 8,  1, 1, 1'b0};
        tbl[3]  = '{0,  8,  1, 1, 1'b0};
        tbl[4]  = '{31, 8,  2, 1, 1'b0};  // hit lands on the final tick
        tbl[5]  = '{2,  6,  2, 1, 1'b0};
        tbl[6]  = '{10, 6,  3, 1, 1'b0};  // 6-2 clamps to 6
        tbl[7]  = '{-1, 6,  3, 2, 1'b0};
        tbl[8]  = '{1,  6,  3, 2, 1'b0};
        tbl[9]  = '{23, 6,  4, 2, 1'b0};  // final-tick hit again
        tbl[10] = '{-1, 6,  4, 3, 1'b1};

        reset_n  = 1'b0;
        start_in = 1'b1;
        hit_in   = 1'b0;
        repeat (3) step();
        chk("rst_new_round", int'(new_round_out), 0);
        chk("rst_active", int'(round_active_out), 0);
        chk("rst_expired", int'(timer_expired_out), 0);
        chk("rst_ms_left", int'(ms_left_out), 0);
        chk("rst_level", int'(level_out), 0);
        chk("rst_misses", int'(misses_out), 0);
        chk("rst_over", int'(game_over_out), 0);
        reset_n = 1'b1;
        repeat (6) step();
        chk("held_start_no_game", nr_pulses, 0);
        chk("held_start_idle", int'(round_active_out), 0);

        start_pulse();
        for (int i = 0; i < 11; i++)
            run_round(tbl[i].hit_off, tbl[i].len, tbl[i].level, tbl[i].misses, tbl[i].over, 1'b0);

        // Restart from GAME_OVER reinitialises level, misses and round length.
        start_pulse();
        run_round(4, 10, 0, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a window.
        step();
        repeat (5) step();
        chk("pre_reset_active", int'(round_active_out), 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_active", int'(round_active_out), 0);
        chk("async_rst_ms_left", int'(ms_left_out), 0);
        chk("async_rst_over", int'(game_over_out), 0);
        step();
        reset_n = 1'b1;
        begin
            int nr0;
            nr0 = nr_pulses;
            repeat (5) step();
            chk("post_reset_idle", nr_pulses - nr0, 0);
        end

        // Stray hit in IDLE, stray hits and start edges during GAP: all ignored.
        hit_in = 1'b1;
        step();
        hit_in = 1'b0;
        step();
        start_pulse();
        run_round(4, 10, 0, 0, 1'b0, 1'b1);
        run_round(-1, 10, 0, 1, 1'b0, 1'b0);

        // Random games against a round-level model.
        for (int g = 0; g < 3; g++) begin
            reset_n = 1'b0;
            step();
            reset_n = 1'b1;
            step();
            start_pulse();
            m_round_ms = INIT; m_level = 0; m_hits = 0; m_misses = 0; m_over = 1'b0;
            rounds = 0;
            while (!m_over && rounds < 40) begin
                int len;
                len    = m_round_ms;
                do_hit = ($urandom_range(0, 3) != 0) || (rounds == 39);
                off    = do_hit ? int'($urandom_range(0, len * TD - 1)) : -1;
                if (do_hit) begin
                    m_hits++;
                    if (m_hits == HPL) begin
                        m_hits     = 0;
                        m_level    = (m_level < 15) ? m_level + 1 : 15;
                        m_round_ms = (m_round_ms - STEP < MINL) ? MINL : m_round_ms - STEP;
                    end
                end else begin
                    m_misses++;
                    m_over = (m_misses == MAXM);
                end
                run_round(off, len, m_level, m_misses, m_over, 1'b0);
                rounds++;
            end
        end

`ifdef ROUND_CTRL_PAUSE_EN
        begin
            int n, frozen;
            reset_n = 1'b0;
            step();
            reset_n = 1'b1;
            step();
            start_pulse();
            n = 0;
            while (!new_round_out && n < 200) begin step(); n++; end
            step();
            repeat (10) step();
            frozen   = int'(ms_left_out);
            pause_in = 1'b1;
            repeat (20) step();
            pause_in = 1'b0;
            chk("pause_ms_frozen", int'(ms_left_out), frozen);
            n = 30;
            while (!timer_expired_out && n < 5000) begin step(); n++; end
            chk("pause_expiry_latency", n, INIT * TD + 20);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
